// File: rtl/xcore_gnrl_dfflr.sv
// Generic DW-bit flop with load enable and synchronous active-high reset.
// Ports:
//   clk    - clock, updates on posedge
//   reset  - synchronous reset to RST_VAL (tie low for storage without reset)
//   lden   - load enable; qout takes dnxt when high
//   dnxt   - next value
//   qout   - registered value
module xcore_gnrl_dfflr #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] val_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= RST_VAL;
    end else if (lden) begin
      val_q <= dnxt;
    end
  end

  assign qout = val_q;

endmodule

// File: rtl/xcore_gnrl_pipe_fifo.sv
// Valid/ready FIFO stage between CPU pipeline stages. Output is always taken
// from registered storage (no bypass), so first-word latency is one cycle.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   flush          - synchronous clear of all entries (pipeline flush)
//   i_vld/i_rdy/i_dat - upstream handshake; i_rdy = !full
//   o_vld/o_rdy/o_dat - downstream handshake; o_vld = !empty
//   count          - occupied entries, 0..DP
module xcore_gnrl_pipe_fifo #(
  parameter int DW = 32,
  parameter int DP = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   i_vld,
  output logic                   i_rdy,
  input  logic [DW-1:0]          i_dat,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [DW-1:0]          o_dat,
  output logic [$clog2(DP):0]    count
);

  localparam int AW = $clog2(DP);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          wptr_en, rptr_en;
  logic          empty, full;
  logic          push, pop, mem_wr;
  logic [DW-1:0] mem_q [DP];

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign i_rdy = ~full;
  assign o_vld = ~empty;

  assign push = i_vld & i_rdy;
  assign pop  = o_vld & o_rdy;

  // A flush discards any push/pop of the same cycle; reset dominates inside
  // the pointer flops themselves.
  assign mem_wr  = push & ~flush & ~reset;
  assign wptr_en = flush | push;
  assign rptr_en = flush | pop;
  assign wptr_d  = flush ? '0 : (wptr_q + PTR_ONE);
  assign rptr_d  = flush ? '0 : (rptr_q + PTR_ONE);

  xcore_gnrl_dfflr #(.DW(AW+1), .RST_VAL('0)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .lden  (wptr_en),
    .dnxt  (wptr_d),
    .qout  (wptr_q)
  );

  xcore_gnrl_dfflr #(.DW(AW+1), .RST_VAL('0)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .lden  (rptr_en),
    .dnxt  (rptr_d),
    .qout  (rptr_q)
  );

  // Storage entries carry no reset; only the pointers define validity.
  for (genvar gi = 0; gi < DP; gi++) begin : g_mem
    logic ent_en;
    assign ent_en = mem_wr & (wptr_q[AW-1:0] == AW'(gi));

    xcore_gnrl_dfflr #(.DW(DW), .RST_VAL('0)) u_ent (
      .clk   (clk),
      .reset (1'b0),
      .lden  (ent_en),
      .dnxt  (i_dat),
      .qout  (mem_q[gi])
    );
  end

  assign o_dat = mem_q[rptr_q[AW-1:0]];
  assign count = wptr_q - rptr_q;

endmodule

// File: tb/tb_xcore_gnrl_pipe_fifo.sv
// Bench for xcore_gnrl_pipe_fifo (DW=8, DP=4): directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_xcore_gnrl_pipe_fifo;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          i_vld, i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld, o_rdy;
  logic [DW-1:0] o_dat;
  logic [2:0]    count;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mdl_q [$];

  always #5 clk = ~clk;

  xcore_gnrl_pipe_fifo #(.DW(DW), .DP(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .count (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare outputs against the model (called at negedge, away from posedge).
  task automatic check_state(input string tag);
    check_eq({tag, ".i_rdy"}, 32'(i_rdy), 32'(mdl_q.size() < DP));
    check_eq({tag, ".o_vld"}, 32'(o_vld), 32'(mdl_q.size() != 0));
    check_eq({tag, ".count"}, 32'(count), 32'(mdl_q.size()));
    if (mdl_q.size() != 0)
      check_eq({tag, ".o_dat"}, 32'(o_dat), 32'(mdl_q[0]));
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input string tag, input logic vld, input logic [DW-1:0] dat,
                      input logic rdy, input logic fl, input logic rs, input bit chk);
    bit do_push, do_pop;
    reset = rs; flush = fl; i_vld = vld; i_dat = dat; o_rdy = rdy;
    if (chk) check_state(tag);
    do_push = vld && (mdl_q.size() < DP);
    do_pop  = rdy && (mdl_q.size() != 0);
    @(posedge clk);
    if (rs || fl) begin
      mdl_q.delete();
    end else begin
      if (do_pop)  void'(mdl_q.pop_front());
      if (do_push) mdl_q.push_back(dat);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] fill_vals [4];
    logic          r_vld;
    logic [DW-1:0] r_dat;
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22;
    fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

    reset = 1'b1; flush = 1'b0; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
    @(negedge clk);

    // Reset then idle.
    step("rst", 0, 8'h00, 0, 0, 1, 0);
    step("rst", 0, 8'h00, 0, 0, 1, 0);
    mdl_q.delete();
    for (int k = 0; k < 3; k++) step("idle", 0, 8'h00, 1, 0, 0, 1);

    // Fill, then a held-off fifth push.
    for (int k = 0; k < 4; k++) step("fill", 1, fill_vals[k], 0, 0, 0, 1);
    step("full_hold", 1, 8'h55, 0, 0, 0, 1);
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_irdy", 32'(i_rdy), 32'd0);

    // Drain order.
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_dat", 32'(o_dat), 32'(fill_vals[k]));
      step("drain", 0, 8'h00, 1, 0, 0, 1);
    end
    check_state("drained");
    check_eq("drained_count", 32'(count), 32'd0);

    // Full with simultaneous i_vld/o_rdy: only the pop happens.
    for (int k = 0; k < 4; k++) step("refill", 1, fill_vals[k], 0, 0, 0, 1);
    step("full_both", 1, 8'h55, 1, 0, 0, 1);
    check_eq("full_both_count", 32'(count), 32'd3);
    step("accept55", 1, 8'h55, 0, 0, 0, 1);
    check_eq("accept55_count", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq("drain2_dat", 32'(o_dat), (k == 3) ? 32'h55 : 32'(fill_vals[k+1]));
      step("drain2", 0, 8'h00, 1, 0, 0, 1);
    end

    // Wrap-around streaming.
    for (int k = 0; k < 20; k++) begin
      step("stream", 1, 8'(k), 1, 0, 0, 1);
      check_eq("stream_count", 32'(count), 32'd1);
      check_eq("stream_dat", 32'(o_dat), 32'(k));
    end
    step("stream_end", 0, 8'h00, 1, 0, 0, 1);

    // Flush mid-operation with a concurrent push.
    for (int k = 0; k < 3; k++) step("pre_fl", 1, 8'(8'hA0 + k), 0, 0, 0, 1);
    step("flush", 1, 8'hAA, 0, 1, 0, 1);
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_ovld", 32'(o_vld), 32'd0);
    step("post_fl", 1, 8'hB1, 0, 0, 0, 1);
    check_eq("post_fl_dat", 32'(o_dat), 32'hB1);

    // Same with reset.
    for (int k = 0; k < 2; k++) step("pre_rs", 1, 8'(8'hC0 + k), 0, 0, 0, 1);
    step("reset", 1, 8'hAA, 0, 0, 1, 1);
    check_eq("reset_count", 32'(count), 32'd0);
    check_eq("reset_ovld", 32'(o_vld), 32'd0);
    check_eq("reset_irdy", 32'(i_rdy), 32'd1);
    step("post_rs", 1, 8'hD1, 0, 0, 0, 1);
    check_eq("post_rs_dat", 32'(o_dat), 32'hD1);

    // Randomized traffic honouring the hold-until-accepted rule.
    r_vld = 1'b0; r_dat = '0;
    for (int k = 0; k < 2000; k++) begin
      logic fl, rs, rdy;
      if (!r_vld) begin
        r_vld = ($urandom_range(0, 99) < 60);
        r_dat = 8'($urandom);
      end
      rdy = ($urandom_range(0, 99) < 50);
      fl  = ($urandom_range(0, 63) == 0);
      rs  = ($urandom_range(0, 127) == 0);
      if (r_vld && (mdl_q.size() < DP)) begin
        step("rand", r_vld, r_dat, rdy, fl, rs, 1);
        r_vld = 1'b0;
      end else begin
        step("rand", r_vld, r_dat, rdy, fl, rs, 1);
      end
    end
    check_state("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
